dsc_mul_ctrl: RTL and testbench

Sequencing controller for the 4-operand deterministic stochastic-computing multiplier (dsc_mul).
- Accepts operand sets over a valid/ready request port and latches them.
- Drives the multiplier's active-high rst and en, waits for its ov (operation finished), and captures z.
- Returns the product, the run cycle count and a timeout flag over a valid/ready response port.
- Replaces the hand-sequenced rst/en/wait(ov) flow so dsc_mul can sit behind a streaming interface.

---
 rtl/dsc_mul_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dsc_mul_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_ctrl.sv
// Sequencing controller for the 4-operand deterministic stochastic-computing multiplier.
// Wraps dsc_mul's rst/en/ov protocol behind valid/ready request and response ports.
module dsc_mul_ctrl #(
    parameter int unsigned INPUT_WIDTH = 4,
    parameter int unsigned CYC_WIDTH   = 18,
    parameter int unsigned TIMEOUT     = 200000,
    parameter int unsigned ZERO_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [INPUT_WIDTH-1:0]   req_a,
    input  logic [INPUT_WIDTH-1:0]   req_b,
    input  logic [INPUT_WIDTH-1:0]   req_c,
    input  logic [INPUT_WIDTH-1:0]   req_d,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [4*INPUT_WIDTH-1:0] rsp_z,
    output logic [CYC_WIDTH-1:0]     rsp_cycles,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic                     mul_rst,
    output logic                     mul_en,
    output logic [INPUT_WIDTH-1:0]   mul_a,
    output logic [INPUT_WIDTH-1:0]   mul_b,
    output logic [INPUT_WIDTH-1:0]   mul_c,
    output logic [INPUT_WIDTH-1:0]   mul_d,
    input  logic [4*INPUT_WIDTH-1:0] mul_z,
    input  logic                     mul_ov
);

    localparam int unsigned ZW = 4 * INPUT_WIDTH;
    localparam logic [CYC_WIDTH-1:0] CNT_LAST = CYC_WIDTH'(TIMEOUT - 1);
    localparam logic [CYC_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic [INPUT_WIDTH-1:0] a_d, b_d, c_d, d_d;
    logic [CYC_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ZW-1:0]          z_q, z_d;
    logic [CYC_WIDTH-1:0]   cyc_q, cyc_d;
    logic                   to_q, to_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   busy_q, busy_d;
    logic                   mul_rst_q, mul_rst_d;
    logic                   mul_en_q, mul_en_d;
    logic                   any_zero;

    assign any_zero = (req_a == '0) || (req_b == '0) || (req_c == '0) || (req_d == '0);

    // Next-state and datapath updates; status outputs decode the next state so they are registered.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        cyc_d   = cyc_q;
        to_d    = to_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d = req_a;
                    b_d = req_b;
                    c_d = req_c;
                    d_d = req_d;
                    if ((ZERO_BYPASS != 0) && any_zero) begin
                        z_d     = '0;
                        cyc_d   = '0;
                        to_d    = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = CLR;
                    end
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CYC_WIDTH'(1);
                // A finishing multiplier takes precedence over a coincident timeout.
                if (mul_ov) begin
                    state_d = SETTLE;
                end else if (cnt_q == CNT_LAST) begin
                    z_d     = '0;
                    cyc_d   = cnt_d;
                    to_d    = 1'b1;
                    state_d = RESP;
                end
            end
            SETTLE: begin
                z_d     = mul_z;
                cyc_d   = cnt_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    to_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
        mul_rst_d   = (state_d == IDLE) || (state_d == CLR) || (state_d == RESP);
        mul_en_d    = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            z_q         <= '0;
            cyc_q       <= '0;
            to_q        <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_rst_q   <= 1'b1;
            mul_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            cyc_q       <= cyc_d;
            to_q        <= to_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            mul_rst_q   <= mul_rst_d;
            mul_en_q    <= mul_en_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_z       = z_q;
    assign rsp_cycles  = cyc_q;
    assign rsp_timeout = to_q;
    assign busy        = busy_q;
    assign mul_rst     = mul_rst_q;
    assign mul_en      = mul_en_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign mul_c       = c_q;
    assign mul_d       = d_q;

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Testbench for dsc_mul_ctrl: behavioural dsc_mul stub, scoreboard of expected responses.
module tb_dsc_mul_ctrl;

    localparam int unsigned IW = 4;
    localparam int unsigned CW = 18;
    localparam int unsigned ZW = 4 * IW;
    localparam int unsigned TO = 100;

    typedef struct {
        logic [ZW-1:0] z;
        logic [CW-1:0] cyc;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [IW-1:0] req_a, req_b, req_c, req_d;
    logic          rsp_valid, rsp_ready;
    logic [ZW-1:0] rsp_z;
    logic [CW-1:0] rsp_cycles;
    logic          rsp_timeout, busy, mul_rst, mul_en;
    logic [IW-1:0] mul_a, mul_b, mul_c, mul_d;
    logic [ZW-1:0] mul_z;
    logic          mul_ov;

    logic          nb_req_valid, nb_req_ready, nb_rsp_valid;
    logic          nb_rsp_ready;
    logic [IW-1:0] nb_req_a, nb_req_b, nb_req_c, nb_req_d;
    logic [ZW-1:0] nb_rsp_z, nb_mul_z;
    logic [CW-1:0] nb_rsp_cycles;
    logic          nb_rsp_timeout, nb_busy, nb_mul_rst, nb_mul_en, nb_mul_ov;
    logic [IW-1:0] nb_mul_a, nb_mul_b, nb_mul_c, nb_mul_d;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0, acc_cyc = 0, last_lat = 0, en_cnt = 0;
    int   ov_cur = 0, ov_next = 0;
    logic rv_prev = 1'b0;
    logic rand_on = 1'b0;
    logic [7:0] scnt, nb_scnt;

    always #5 clk = ~clk;

    dsc_mul_ctrl #(.INPUT_WIDTH(IW), .CYC_WIDTH(CW), .TIMEOUT(TO), .ZERO_BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout),
        .busy(busy), .mul_rst(mul_rst), .mul_en(mul_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
        .mul_z(mul_z), .mul_ov(mul_ov)
    );

    dsc_mul_ctrl #(.INPUT_WIDTH(IW), .CYC_WIDTH(CW), .TIMEOUT(TO), .ZERO_BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .req_valid(nb_req_valid), .req_ready(nb_req_ready),
        .req_a(nb_req_a), .req_b(nb_req_b), .req_c(nb_req_c), .req_d(nb_req_d),
        .rsp_valid(nb_rsp_valid), .rsp_ready(nb_rsp_ready),
        .rsp_z(nb_rsp_z), .rsp_cycles(nb_rsp_cycles), .rsp_timeout(nb_rsp_timeout),
        .busy(nb_busy), .mul_rst(nb_mul_rst), .mul_en(nb_mul_en),
        .mul_a(nb_mul_a), .mul_b(nb_mul_b), .mul_c(nb_mul_c), .mul_d(nb_mul_d),
        .mul_z(nb_mul_z), .mul_ov(nb_mul_ov)
    );

    // dsc_mul stubs: ov asserted during the Nth enabled cycle, z = a*b*c*d.
    always @(posedge clk) begin
        if (mul_rst) scnt <= 8'd0;
        else if (mul_en) scnt <= scnt + 8'd1;
        if (nb_mul_rst) nb_scnt <= 8'd0;
        else if (nb_mul_en) nb_scnt <= nb_scnt + 8'd1;
    end
    assign mul_ov    = (ov_cur != 0) && mul_en && (int'(scnt) == ov_cur - 1);
    assign mul_z     = ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c) * ZW'(mul_d);
    assign nb_mul_ov = nb_mul_en && (nb_scnt == 8'd39);
    assign nb_mul_z  = ZW'(nb_mul_a) * ZW'(nb_mul_b) * ZW'(nb_mul_c) * ZW'(nb_mul_d);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [IW-1:0] a, b, c, d, input int ov);
        exp_t e;
        if (a == 0 || b == 0 || c == 0 || d == 0) begin
            e.z = '0; e.cyc = '0; e.to = 1'b0;
        end else if (ov == 0 || ov > int'(TO)) begin
            e.z = '0; e.cyc = CW'(TO); e.to = 1'b1;
        end else begin
            e.z = ZW'(int'(a) * int'(b) * int'(c) * int'(d)); e.cyc = CW'(ov); e.to = 1'b0;
        end
        return e;
    endfunction

    // Monitor: handshake bookkeeping, latency, enabled-cycle count and scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mul_en) en_cnt++;
        if (req_valid && req_ready) begin
            acc_cyc = cyc;
            en_cnt  = 0;
            ov_cur  = ov_next;
        end
        if (rsp_valid && !rv_prev) last_lat = cyc - acc_cyc;
        rv_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_z", 32'(rsp_z), 32'(e.z));
                chk("rsp_cycles", 32'(rsp_cycles), 32'(e.cyc));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                chk("rsp_cycles_vs_en", 32'(rsp_cycles), 32'(en_cnt));
            end
        end
    end

    task automatic send(input logic [IW-1:0] a, b, c, d, input int ov);
        @(posedge clk); #1;
        ov_next = ov;
        req_a = a; req_b = b; req_c = c; req_d = d;
        req_valid = 1'b1;
        sb_q.push_back(model(a, b, c, d, ov));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ZW-1:0] z0;
        logic [CW-1:0] c0;
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        nb_req_valid = 1'b0; nb_rsp_ready = 1'b1;
        nb_req_a = '0; nb_req_b = '0; nb_req_c = '0; nb_req_d = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mul_rst", 32'(mul_rst), 32'd1);
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_z", 32'(rsp_z), 32'd0);
        chk("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Full run: 40 enabled cycles, latency N+3.
        rsp_ready = 1'b1;
        send(4'd15, 4'd15, 4'd15, 4'd15, 40);
        drain();
        chk("lat_full", 32'(last_lat), 32'd43);

        // Zero bypass versus full run with bypass disabled.
        send(4'd7, 4'd0, 4'd3, 4'd9, 40);
        drain();
        chk("lat_bypass", 32'(last_lat), 32'd1);
        @(posedge clk); #1;
        nb_req_a = 4'd7; nb_req_b = 4'd0; nb_req_c = 4'd3; nb_req_d = 4'd9;
        nb_req_valid = 1'b1;
        @(posedge clk); #1;
        nb_req_valid = 1'b0;
        for (int i = 0; i < 500 && !nb_rsp_valid; i++) @(negedge clk);
        chk("nb_rsp_valid", 32'(nb_rsp_valid), 32'd1);
        chk("nb_rsp_z", 32'(nb_rsp_z), 32'd0);
        chk("nb_rsp_cycles", 32'(nb_rsp_cycles), 32'd40);
        chk("nb_rsp_timeout", 32'(nb_rsp_timeout), 32'd0);

        // Timeout, then ov on the last allowed cycle beats the timeout.
        send(4'd9, 4'd9, 4'd9, 4'd9, 0);
        drain();
        send(4'd3, 4'd5, 4'd7, 4'd2, 100);
        drain();

        // Response backpressure for 20 cycles with a competing request pending.
        rsp_ready = 1'b0;
        send(4'd2, 4'd2, 4'd2, 4'd2, 5);
        for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
        chk("hold_valid_up", 32'(rsp_valid), 32'd1);
        z0 = rsp_z; c0 = rsp_cycles;
        @(posedge clk); #1;
        ov_next = 3;
        req_a = 4'd1; req_b = 4'd1; req_c = 4'd1; req_d = 4'd1;
        req_valid = 1'b1;
        sb_q.push_back(model(4'd1, 4'd1, 4'd1, 4'd1, 3));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_z", 32'(rsp_z), 32'(z0));
            chk("hold_rsp_cycles", 32'(rsp_cycles), 32'(c0));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_mul_en", 32'(mul_en), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("hold_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();

        // Asynchronous reset in the middle of a run drops the operation.
        send(4'd6, 4'd6, 4'd6, 4'd6, 50);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mul_rst", 32'(mul_rst), 32'd1);
        chk("arst_mul_en", 32'(mul_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        send(4'd2, 4'd3, 4'd4, 4'd5, 20);
        drain();

        // Random back-to-back traffic with random response backpressure.
        rand_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 10; n++)
                    send(IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15)),
                         IW'($urandom_range(0, 15)), IW'($urandom_range(0, 15)),
                         int'($urandom_range(1, 60)));
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
